// File: rtl/chipin_pkg.sv
// Shared types and constants for the chip-gate servo sequencer and other servo users.
package chipin_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [9:0] POS_CLOSED_DEF = 10'd0;
  localparam logic [9:0] POS_OPEN_DEF   = 10'd255;

  // Width of a millisecond counter able to reach the larger of two dwells.
  function automatic int unsigned ms_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/ms_dwell_timer.sv
// Millisecond dwell timer: pulses expired on the final cycle of a dwell_ms long interval.
module ms_dwell_timer #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned MS_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  input  logic [MS_W-1:0] dwell_ms,
  output logic            expired
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned CYC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CYC_W-1:0] r_cyc;
  logic [MS_W-1:0]  r_ms;
  logic             w_tick;

  assign w_tick  = (r_cyc == CYC_W'(TICK_DIV - 1));
  assign expired = w_tick && (r_ms == (dwell_ms - MS_W'(1)));

  // Restart zeroes both counters so the first cycle of a new dwell is cycle 0 of ms 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_ms  <= '0;
    end else if (restart) begin
      r_cyc <= '0;
      r_ms  <= '0;
    end else if (w_tick) begin
      r_cyc <= '0;
      r_ms  <= r_ms + MS_W'(1);
    end else begin
      r_cyc <= r_cyc + CYC_W'(1);
    end
  end

endmodule

// File: rtl/chip_dispense_sequencer.sv
// Opens and closes the chip gate servo once per chip for each accepted dispense request.
module chip_dispense_sequencer
  import chipin_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter logic [9:0]  POS_CLOSED = POS_CLOSED_DEF,
  parameter logic [9:0]  POS_OPEN   = POS_OPEN_DEF,
  parameter int unsigned OPEN_MS    = 200,
  parameter int unsigned CLOSE_MS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] chip_count,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [7:0] dispensed,
  output logic [9:0] servo_pos
);

  localparam int unsigned MS_W = ms_width(OPEN_MS, CLOSE_MS);

  state_t          r_state;
  logic [7:0]      r_remaining;
  logic            r_abort_q;
  logic            w_accept;
  logic            w_expired;
  logic            w_restart;
  logic [MS_W-1:0] w_dwell_ms;

  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_dwell_ms = (r_state == OPENING) ? MS_W'(OPEN_MS) : MS_W'(CLOSE_MS);
  // Held in IDLE/FINISH and pulsed on every dwell exit, so each state entry starts from zero.
  assign w_restart  = (r_state == IDLE) || (r_state == FINISH) || w_expired ||
                      ((r_state == OPENING) && abort);

  ms_dwell_timer #(
    .CLK_HZ (CLK_HZ),
    .MS_W   (MS_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (w_restart),
    .dwell_ms (w_dwell_ms),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_abort_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dispensed   <= '0;
      servo_pos   <= POS_CLOSED;
    end else begin
      case (r_state)
        IDLE: begin
          r_abort_q <= 1'b0;
          if (w_accept) begin
            r_remaining <= chip_count;
            dispensed   <= '0;
            busy        <= 1'b1;
            if (chip_count != 8'd0) begin
              r_state   <= OPENING;
              servo_pos <= POS_OPEN;
            end else begin
              r_state <= FINISH;
              done    <= 1'b1;
            end
          end
        end
        OPENING: begin
          // An abort in the final open cycle still wins over the chip count.
          if (abort) begin
            r_abort_q <= 1'b1;
            r_state   <= CLOSING;
            servo_pos <= POS_CLOSED;
          end else if (w_expired) begin
            if (dispensed != 8'hFF) dispensed <= dispensed + 8'd1;
            r_remaining <= r_remaining - 8'd1;
            r_state     <= CLOSING;
            servo_pos   <= POS_CLOSED;
          end
        end
        CLOSING: begin
          if (abort) r_abort_q <= 1'b1;
          if (w_expired) begin
            if ((r_remaining == 8'd0) || r_abort_q || abort) begin
              r_state <= FINISH;
              done    <= 1'b1;
            end else begin
              r_state   <= OPENING;
              servo_pos <= POS_OPEN;
            end
          end
        end
        FINISH: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          r_abort_q <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_dispense_sequencer.sv
// Directed bench for chip_dispense_sequencer with a 4-cycle ms tick, 2 ms open, 3 ms close.
module tb_chip_dispense_sequencer;

  localparam logic [9:0] P_OPEN   = 10'd255;
  localparam logic [9:0] P_CLOSED = 10'd0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] chip_count;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] dispensed;
  logic [9:0] servo_pos;

  int errors = 0;
  int checks = 0;
  logic [9:0] trace [1:256];

  chip_dispense_sequencer #(
    .CLK_HZ     (4000),
    .POS_CLOSED (P_CLOSED),
    .POS_OPEN   (P_OPEN),
    .OPEN_MS    (2),
    .CLOSE_MS   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chip_count (chip_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .dispensed  (dispensed),
    .servo_pos  (servo_pos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; returns sampling in the first cycle after the accepting edge.
  task automatic do_start(input logic [7:0] cnt);
    chip_count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records servo_pos per cycle (k=1 is the cycle after accept) until done or limit.
  task automatic observe(input int limit, input int abort_k, input int start_k,
                         input logic [7:0] new_cnt, output int done_at, output int opens,
                         output logic busy_first, output logic busy_at_done,
                         output logic busy_after, output logic done_after);
    done_at = -1; opens = 0;
    busy_first = busy; busy_at_done = 1'b0; busy_after = 1'b1; done_after = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) tick();
      abort = (k == abort_k);
      start = (k == start_k);
      if (k == start_k) chip_count = new_cnt;
      trace[k] = servo_pos;
      if (servo_pos == P_OPEN) opens++;
      if (done === 1'b1) begin
        done_at = k;
        busy_at_done = busy;
        break;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    if (done_at > 0) begin
      tick();
      busy_after = busy;
      done_after = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chip_count = 8'd0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (dispensed !== 8'd0) begin errors++; $display("FAIL reset_dispensed: got %0d want 0", dispensed); end
    checks++; if (servo_pos !== P_CLOSED) begin errors++; $display("FAIL reset_servo: got %0d want %0d", servo_pos, P_CLOSED); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_chips();
    int d, o, bad;
    logic bf, bd, ba, da;
    do_start(8'd3);
    checks++; if (servo_pos !== P_OPEN) begin errors++; $display("FAIL t1_open_latency: got %0d want %0d", servo_pos, P_OPEN); end
    observe(100, 0, 0, 8'd0, d, o, bf, bd, ba, da);
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL t1_busy_latency: got %b want 1", bf); end
    checks++; if (d != 61) begin errors++; $display("FAIL t1_done_at: got %0d want 61", d); end
    bad = 0;
    for (int k = 1; k <= 60; k++)
      if (trace[k] !== ((((k - 1) % 20) < 8) ? P_OPEN : P_CLOSED)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL t1_servo_pattern: got %0d bad cycles want 0", bad); end
    checks++; if (dispensed !== 8'd3) begin errors++; $display("FAIL t1_dispensed: got %0d want 3", dispensed); end
    checks++; if (bd !== 1'b1) begin errors++; $display("FAIL t1_busy_at_done: got %b want 1", bd); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", ba); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL t1_done_width: got %b want 0", da); end
    tick();
  endtask

  task automatic test_zero_chips();
    int d, o;
    logic bf, bd, ba, da;
    do_start(8'd0);
    observe(10, 0, 0, 8'd0, d, o, bf, bd, ba, da);
    checks++; if (d != 1) begin errors++; $display("FAIL t2_done_at: got %0d want 1", d); end
    checks++; if (o != 0) begin errors++; $display("FAIL t2_gate_moved: got %0d open cycles want 0", o); end
    checks++; if (dispensed !== 8'd0) begin errors++; $display("FAIL t2_dispensed: got %0d want 0", dispensed); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL t2_busy_after: got %b want 0", ba); end
    tick();
  endtask

  task automatic test_abort_opening();
    int d, o;
    logic bf, bd, ba, da;
    do_start(8'd5);
    observe(200, 24, 0, 8'd0, d, o, bf, bd, ba, da);
    checks++; if (d != 37) begin errors++; $display("FAIL t3_done_at: got %0d want 37", d); end
    checks++; if (o != 12) begin errors++; $display("FAIL t3_open_cycles: got %0d want 12", o); end
    checks++; if (trace[25] !== P_CLOSED) begin errors++; $display("FAIL t3_close_after_abort: got %0d want %0d", trace[25], P_CLOSED); end
    checks++; if (dispensed !== 8'd1) begin errors++; $display("FAIL t3_dispensed: got %0d want 1", dispensed); end
    tick();
  endtask

  task automatic test_abort_closing();
    int d, o;
    logic bf, bd, ba, da;
    do_start(8'd4);
    observe(200, 12, 0, 8'd0, d, o, bf, bd, ba, da);
    checks++; if (d != 21) begin errors++; $display("FAIL t4_done_at: got %0d want 21", d); end
    checks++; if (o != 8) begin errors++; $display("FAIL t4_open_cycles: got %0d want 8", o); end
    checks++; if (dispensed !== 8'd1) begin errors++; $display("FAIL t4_dispensed: got %0d want 1", dispensed); end
    tick();
  endtask

  task automatic test_abort_idle();
    chip_count = 8'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t_idle_abort_busy: got %b want 0", busy); end
    checks++; if (servo_pos !== P_CLOSED) begin errors++; $display("FAIL t_idle_abort_servo: got %0d want %0d", servo_pos, P_CLOSED); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t_idle_abort_done: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int d, o;
    logic bf, bd, ba, da;
    do_start(8'd2);
    observe(200, 0, 5, 8'd7, d, o, bf, bd, ba, da);
    checks++; if (d != 41) begin errors++; $display("FAIL t5_done_at: got %0d want 41", d); end
    checks++; if (o != 16) begin errors++; $display("FAIL t5_open_cycles: got %0d want 16", o); end
    checks++; if (dispensed !== 8'd2) begin errors++; $display("FAIL t5_dispensed: got %0d want 2", dispensed); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL t5_busy_after: got %b want 0", ba); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int d, o, stray;
    logic bf, bd, ba, da;
    do_start(8'd3);
    tick(); tick();
    checks++; if (servo_pos !== P_OPEN) begin errors++; $display("FAIL t6_open_before_reset: got %0d want %0d", servo_pos, P_OPEN); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (servo_pos !== P_CLOSED) begin errors++; $display("FAIL t6_servo_async: got %0d want %0d", servo_pos, P_CLOSED); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy_async: got %b want 0", busy); end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL t6_no_done: got %0d done cycles want 0", stray); end
    do_start(8'd1);
    observe(60, 0, 0, 8'd0, d, o, bf, bd, ba, da);
    checks++; if (d != 21) begin errors++; $display("FAIL t6_restart_done_at: got %0d want 21", d); end
    checks++; if (dispensed !== 8'd1) begin errors++; $display("FAIL t6_restart_dispensed: got %0d want 1", dispensed); end
    tick();
  endtask

  initial begin
    test_reset();
    test_three_chips();
    test_zero_chips();
    test_abort_opening();
    test_abort_closing();
    test_abort_idle();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
